// File: rtl/csa_frame_accumulator.sv
`default_nettype none
// ============================================================================
// csa_frame_accumulator: per-frame carry-save reduction of x+y+z triples with
// a single carry-propagate resolve and overflow flag.   Revision: 1.0
// ============================================================================
module csa_frame_accumulator #(
  parameter int FRAME_LEN = 8,
  parameter int ACC_W     = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       x,
  input  logic [3:0]       y,
  input  logic [3:0]       z,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] sum,
  output logic             ovf
);

  localparam logic [1:0] c_idle    = 2'd0;
  localparam logic [1:0] c_accum   = 2'd1;
  localparam logic [1:0] c_resolve = 2'd2;
  localparam logic [1:0] c_output  = 2'd3;

  localparam logic [7:0] c_frame_len = 8'(FRAME_LEN);

  logic [1:0]       r_state;
  logic [13:0]      r_s;
  logic [13:0]      r_c;
  logic [7:0]       r_cnt;
  logic             r_in_ready;
  logic             r_out_valid;
  logic [ACC_W-1:0] r_sum;
  logic             r_ovf;

  logic [3:0]  w_ps;
  logic [3:0]  w_pc;
  logic [5:0]  w_t;
  logic [13:0] w_t14;
  logic [13:0] w_maj;
  logic [13:0] w_s_nxt;
  logic [13:0] w_c_nxt;
  logic [13:0] w_total;
  logic [7:0]  w_cnt_inc;
  logic        w_accept;
  logic        w_ovf;

  // Beat operand: 3:2 compress x/y/z, then a short add into 6 bits.
  assign w_ps  = x ^ y ^ z;
  assign w_pc  = (x & y) | (x & z) | (y & z);
  assign w_t   = {2'b00, w_ps} + {1'b0, w_pc, 1'b0};
  assign w_t14 = {8'd0, w_t};

  assign w_maj   = (r_s & r_c) | (r_s & w_t14) | (r_c & w_t14);
  assign w_s_nxt = r_s ^ r_c ^ w_t14;
  assign w_c_nxt = w_maj << 1;

  assign w_total   = r_s + r_c;
  assign w_ovf     = (w_total >> ACC_W) != 14'd0;
  assign w_cnt_inc = r_cnt + 8'd1;
  assign w_accept  = in_valid & r_in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= c_idle;
      r_s         <= 14'd0;
      r_c         <= 14'd0;
      r_cnt       <= 8'd0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_sum       <= '0;
      r_ovf       <= 1'b0;
    end else if (clr) begin
      // Abort: sum/ovf deliberately keep their last value.
      r_state     <= c_idle;
      r_s         <= 14'd0;
      r_c         <= 14'd0;
      r_cnt       <= 8'd0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        c_idle: begin
          if (w_accept) begin
            r_s   <= w_t14;
            r_c   <= 14'd0;
            r_cnt <= 8'd1;
            if (c_frame_len == 8'd1) begin
              r_state    <= c_resolve;
              r_in_ready <= 1'b0;
            end else begin
              r_state    <= c_accum;
            end
          end
        end
        c_accum: begin
          if (w_accept) begin
            r_s   <= w_s_nxt;
            r_c   <= w_c_nxt;
            r_cnt <= w_cnt_inc;
            if (w_cnt_inc == c_frame_len) begin
              r_state    <= c_resolve;
              r_in_ready <= 1'b0;
            end
          end
        end
        c_resolve: begin
          r_sum       <= w_total[ACC_W-1:0];
          r_ovf       <= w_ovf;
          r_out_valid <= 1'b1;
          r_state     <= c_output;
        end
        c_output: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= c_idle;
            r_s         <= 14'd0;
            r_c         <= 14'd0;
            r_cnt       <= 8'd0;
          end
        end
        default: begin
          r_state     <= c_idle;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign sum       = r_sum;
  assign ovf       = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_csa_frame_accumulator.sv
`default_nettype none
// ============================================================================
// tb_csa_frame_accumulator: directed, table-driven checks of two accumulator
// configurations (4-beat/10-bit and 8-beat/8-bit).   Revision: 1.0
// ============================================================================
module tb_csa_frame_accumulator;

  logic       clk = 1'b0;
  logic       rst;
  logic       clr;
  logic [3:0] x, y, z;
  logic       out_ready;

  logic       iv_a, ir_a, ov_a, ovf_a;
  logic [9:0] sum_a;
  logic       iv_b, ir_b, ov_b, ovf_b;
  logic [7:0] sum_b;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  csa_frame_accumulator #(.FRAME_LEN(4), .ACC_W(10)) u_dut_a (
    .clk(clk), .rst(rst), .clr(clr),
    .in_valid(iv_a), .in_ready(ir_a),
    .x(x), .y(y), .z(z),
    .out_valid(ov_a), .out_ready(out_ready),
    .sum(sum_a), .ovf(ovf_a)
  );

  csa_frame_accumulator #(.FRAME_LEN(8), .ACC_W(8)) u_dut_b (
    .clk(clk), .rst(rst), .clr(clr),
    .in_valid(iv_b), .in_ready(ir_b),
    .x(x), .y(y), .z(z),
    .out_valid(ov_b), .out_ready(out_ready),
    .sum(sum_b), .ovf(ovf_b)
  );

  typedef struct {
    int               sel;
    int               n;
    logic [7:0][11:0] trips;
    logic [13:0]      es;
    logic             eo;
  } vec_t;

  vec_t vecs [6];

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    else
      n_pass++;
  endfunction

  function automatic logic g_ir(int sel);  return sel != 0 ? ir_b : ir_a;   endfunction
  function automatic logic g_ov(int sel);  return sel != 0 ? ov_b : ov_a;   endfunction
  function automatic logic g_ovf(int sel); return sel != 0 ? ovf_b : ovf_a; endfunction
  function automatic logic [13:0] g_sum(int sel);
    return sel != 0 ? {6'd0, sum_b} : {4'd0, sum_a};
  endfunction

  function automatic logic [7:0][11:0] rep(logic [3:0] a, logic [3:0] b, logic [3:0] c);
    logic [7:0][11:0] r;
    for (int i = 0; i < 8; i++) r[i] = {a, b, c};
    return r;
  endfunction

  task automatic set_iv(int sel, logic v);
    if (sel != 0) iv_b = v; else iv_a = v;
  endtask

  // Presents n beats back to back; returns at edge+1 after the last accept.
  task automatic feed(int sel, int n, logic [7:0][11:0] trips);
    for (int i = 0; i < n; i++) begin
      {x, y, z} = trips[i];
      set_iv(sel, 1'b1);
      check("in_ready_during_frame", 32'(g_ir(sel)), 32'd1);
      @(posedge clk); #1;
    end
    set_iv(sel, 1'b0);
  endtask

  // Full frame with out_ready = 1, checking exact latency and in_ready gap.
  task automatic run_frame(int sel, int n, logic [7:0][11:0] trips,
                           logic [13:0] es, logic eo);
    out_ready = 1'b1;
    feed(sel, n, trips);
    check("resolve_in_ready", 32'(g_ir(sel)), 32'd0);
    check("resolve_out_valid", 32'(g_ov(sel)), 32'd0);
    @(posedge clk); #1;
    check("out_valid", 32'(g_ov(sel)), 32'd1);
    check("output_in_ready", 32'(g_ir(sel)), 32'd0);
    check("sum", 32'(g_sum(sel)), 32'(es));
    check("ovf", 32'(g_ovf(sel)), 32'(eo));
    @(posedge clk); #1;
    check("post_hs_out_valid", 32'(g_ov(sel)), 32'd0);
    check("post_hs_in_ready", 32'(g_ir(sel)), 32'd1);
  endtask

  initial begin
    logic [7:0][11:0] tr;
    int pat [7];

    vecs[0].sel = 0; vecs[0].n = 4; vecs[0].trips = rep(4'd0, 4'd0, 4'd0);
    vecs[0].trips[0] = {4'd1, 4'd2, 4'd3};
    vecs[0].trips[1] = {4'd4, 4'd5, 4'd6};
    vecs[0].trips[2] = {4'd7, 4'd8, 4'd9};
    vecs[0].trips[3] = {4'd15, 4'd15, 4'd15};
    vecs[0].es = 14'd90;  vecs[0].eo = 1'b0;
    vecs[1].sel = 0; vecs[1].n = 4; vecs[1].trips = rep(4'd0, 4'd0, 4'd0);
    vecs[1].es = 14'd0;   vecs[1].eo = 1'b0;
    vecs[2].sel = 0; vecs[2].n = 4; vecs[2].trips = rep(4'd15, 4'd15, 4'd15);
    vecs[2].es = 14'd180; vecs[2].eo = 1'b0;
    vecs[3].sel = 1; vecs[3].n = 8; vecs[3].trips = rep(4'd15, 4'd15, 4'd15);
    vecs[3].es = 14'd104; vecs[3].eo = 1'b1;
    // 8 x 32 = 256: exactly at the 8-bit wrap.
    vecs[4].sel = 1; vecs[4].n = 8; vecs[4].trips = rep(4'd15, 4'd15, 4'd2);
    vecs[4].es = 14'd0;   vecs[4].eo = 1'b1;
    // 7 x 32 + 31 = 255: largest value without overflow.
    vecs[5].sel = 1; vecs[5].n = 8; vecs[5].trips = rep(4'd15, 4'd15, 4'd2);
    vecs[5].trips[7] = {4'd15, 4'd15, 4'd1};
    vecs[5].es = 14'd255; vecs[5].eo = 1'b0;

    rst = 1'b1; clr = 1'b0; x = '0; y = '0; z = '0;
    iv_a = 1'b0; iv_b = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_in_ready", 32'(ir_a), 32'd1);
    check("reset_out_valid", 32'(ov_a), 32'd0);
    check("reset_sum", 32'(sum_a), 32'd0);
    check("reset_ovf", 32'(ovf_b), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++)
      run_frame(vecs[i].sel, vecs[i].n, vecs[i].trips, vecs[i].es, vecs[i].eo);

    // Gapped in_valid: idle cycles must not advance the beat count.
    pat = '{1, 0, 0, 1, 0, 1, 1};
    {x, y, z} = {4'd2, 4'd2, 4'd2};
    for (int i = 0; i < 7; i++) begin
      iv_a = pat[i][0];
      check("gap_in_ready", 32'(ir_a), 32'd1);
      check("gap_out_valid", 32'(ov_a), 32'd0);
      @(posedge clk); #1;
    end
    iv_a = 1'b0;
    check("gap_resolve_out_valid", 32'(ov_a), 32'd0);
    @(posedge clk); #1;
    check("gap_out_valid_done", 32'(ov_a), 32'd1);
    check("gap_sum", 32'(sum_a), 32'd24);
    @(posedge clk); #1;

    // Backpressure with in_valid held high against a busy block.
    out_ready = 1'b0;
    feed(0, 4, rep(4'd5, 4'd5, 4'd5));
    @(posedge clk); #1;
    {x, y, z} = {4'd15, 4'd15, 4'd15};
    iv_a = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("bp_out_valid", 32'(ov_a), 32'd1);
      check("bp_sum", 32'(sum_a), 32'd60);
      check("bp_ovf", 32'(ovf_a), 32'd0);
      check("bp_in_ready", 32'(ir_a), 32'd0);
      @(posedge clk); #1;
    end
    iv_a = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_hs_out_valid", 32'(ov_a), 32'd0);
    check("bp_hs_in_ready", 32'(ir_a), 32'd1);
    run_frame(0, 4, rep(4'd1, 4'd1, 4'd1), 14'd12, 1'b0);

    // Asynchronous reset two beats into a frame, checked before any edge.
    feed(0, 2, rep(4'd1, 4'd2, 4'd3));
    #2 rst = 1'b1;
    #1;
    check("arst_in_ready", 32'(ir_a), 32'd1);
    check("arst_out_valid", 32'(ov_a), 32'd0);
    check("arst_sum", 32'(sum_a), 32'd0);
    check("arst_ovf", 32'(ovf_a), 32'd0);
    rst = 1'b0;
    run_frame(0, 4, rep(4'd1, 4'd1, 4'd1), 14'd12, 1'b0);

    // clr while a result is waiting.
    out_ready = 1'b0;
    feed(0, 4, rep(4'd1, 4'd1, 4'd1));
    @(posedge clk); #1;
    check("clr_out_pre_valid", 32'(ov_a), 32'd1);
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    check("clr_out_valid", 32'(ov_a), 32'd0);
    check("clr_out_in_ready", 32'(ir_a), 32'd1);
    run_frame(0, 4, rep(4'd3, 4'd3, 4'd3), 14'd36, 1'b0);

    // clr mid-frame with a concurrent beat that must be dropped.
    tr = rep(4'd7, 4'd7, 4'd7);
    feed(0, 2, tr);
    iv_a = 1'b1;
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    iv_a = 1'b0;
    check("clr_acc_out_valid", 32'(ov_a), 32'd0);
    check("clr_acc_in_ready", 32'(ir_a), 32'd1);
    run_frame(0, 4, rep(4'd3, 4'd3, 4'd3), 14'd36, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
